// File: rtl/flopd_pipe.sv
// flopd_pipe: WIDTH-bit, DEPTH-stage registered delay line with a valid bit per stage.
//
// Each stage holds one data word and its valid bit. The stages advance together when
// en_i is high and hold when it is low. flush_i clears every valid bit. reset_i is
// synchronous and active high; it loads RESET_VAL into every data stage and clears
// every valid bit. Priority is reset > flush > en > hold. Outputs come straight from
// the last stage, so there is no combinational path from the inputs to the outputs.
//
// Optional feature, guarded by the macro FLOPD_PIPE_OCC_EN:
//   occupancy_o  an up/down count of the valid stages. When the macro is defined,
//                simulation also checks the count against a popcount of the valid bits.
//
// Parameters:
//   WIDTH      data word width in bits (>= 1)
//   DEPTH      number of stages, equal to the latency in enabled cycles (>= 1)
//   RESET_VAL  value loaded into every data stage on reset
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset
//   en_i         advance enable (0 = hold all stages)
//   flush_i      clear all valid bits
//   input_d_i    data into stage 0
//   in_valid_i   qualifier for input_d_i
//   output_q_o   data from stage DEPTH-1
//   out_valid_o  valid bit of stage DEPTH-1
//   occupancy_o  number of valid stages (only with FLOPD_PIPE_OCC_EN)
module flopd_pipe #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           input_d_i,
    input  logic                       in_valid_i,
    output logic [WIDTH-1:0]           output_q_o,
    output logic                       out_valid_o
`ifdef FLOPD_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
`endif
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    // Data shifts whenever en_i is high, valid or not. A flush only clears the
    // valid bits, so the data still moves (or holds) exactly as en_i says.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (en_i) begin
            data_d[0] = input_d_i;
            vld_d[0]  = in_valid_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end
        if (flush_i) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            vld_q <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign output_q_o  = data_q[DEPTH-1];
    assign out_valid_o = vld_q[DEPTH-1];

`ifdef FLOPD_PIPE_OCC_EN
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic [OccW-1:0] occ_q;
    logic [OccW-1:0] occ_d;
    logic [OccW-1:0] vld_cnt;

    // The sum may wrap for a moment when OccW is narrow. The final value is still
    // exact, because a full pipe always has its last stage valid.
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (en_i) begin
            occ_d = occ_q + OccW'(in_valid_i) - OccW'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o = occ_q;

    // Reference popcount. Only the assertion reads it.
    always_comb begin
        vld_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            vld_cnt = vld_cnt + OccW'(vld_q[i]);
        end
    end

    occ_matches_popcount: assert property (@(posedge clk_i) disable iff (reset_i)
        occ_q == vld_cnt);
`endif

endmodule

// File: tb/tb_flopd_pipe.sv
module tb_flopd_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: WIDTH=8, DEPTH=4, RESET_VAL=0
    logic       rst = 1'b1, en = 1'b0, fl = 1'b0, iv = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       dval;

    // Degenerate DUT: WIDTH=16, DEPTH=1, non-zero reset value
    logic        r2 = 1'b1, e2 = 1'b0, f2 = 1'b0, v2 = 1'b0;
    logic [15:0] d2 = 16'h0000;
    logic [15:0] q2;
    logic        qv2;

`ifdef FLOPD_PIPE_OCC_EN
    logic [2:0] occ;
    logic [0:0] occ2;
`endif

    flopd_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .en_i        (en),
        .flush_i     (fl),
        .input_d_i   (din),
        .in_valid_i  (iv),
        .output_q_o  (dout),
        .out_valid_o (dval)
`ifdef FLOPD_PIPE_OCC_EN
        ,
        .occupancy_o (occ)
`endif
    );

    flopd_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'hA5A5)) dut1 (
        .clk_i       (clk),
        .reset_i     (r2),
        .en_i        (e2),
        .flush_i     (f2),
        .input_d_i   (d2),
        .in_valid_i  (v2),
        .output_q_o  (q2),
        .out_valid_o (qv2)
`ifdef FLOPD_PIPE_OCC_EN
        ,
        .occupancy_o (occ2)
`endif
    );

    typedef struct {
        logic        rst, en, fl, iv;
        logic [15:0] d;
        logic        ev;
        logic [15:0] eq;
        int          eo;
    } vec_t;

    vec_t       vecs [$];
    vec_t       vecs1 [$];
    logic [7:0] sb [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic f, input logic v,
                       input logic [15:0] d, input logic ev, input logic [15:0] eq,
                       input int eo);
        vec_t t;
        t = '{rst: r, en: e, fl: f, iv: v, d: d, ev: ev, eq: eq, eo: eo};
        vecs.push_back(t);
    endtask

    task automatic add1(input logic r, input logic e, input logic f, input logic v,
                        input logic [15:0] d, input logic ev, input logic [15:0] eq,
                        input int eo);
        vec_t t;
        t = '{rst: r, en: e, fl: f, iv: v, d: d, ev: ev, eq: eq, eo: eo};
        vecs1.push_back(t);
    endtask

    initial begin
        logic [4:0] pat;
        logic       mv [4];

        // Expected state after each edge is worked out by hand from the stage contents.
        //  rst en fl iv data    ev  q       occ
        add(1, 0, 0, 0, 16'h00, 0, 16'h00, 0);   // reset
        add(1, 0, 0, 0, 16'h00, 0, 16'h00, 0);
        add(0, 1, 0, 1, 16'hCA, 0, 16'h00, 1);   // stream CA 8A CA 55
        add(0, 1, 0, 1, 16'h8A, 0, 16'h00, 2);
        add(0, 1, 0, 1, 16'hCA, 0, 16'h00, 3);
        add(0, 1, 0, 1, 16'h55, 1, 16'hCA, 4);
        add(0, 1, 0, 1, 16'h11, 1, 16'h8A, 4);   // feed 11, 22
        add(0, 1, 0, 1, 16'h22, 1, 16'hCA, 4);
        add(0, 0, 0, 1, 16'h99, 1, 16'hCA, 4);   // stall for 3 cycles
        add(0, 0, 0, 1, 16'h99, 1, 16'hCA, 4);
        add(0, 0, 0, 1, 16'h99, 1, 16'hCA, 4);
        add(0, 1, 0, 0, 16'h00, 1, 16'h55, 3);   // resume
        add(0, 1, 0, 0, 16'h00, 1, 16'h11, 2);
        add(0, 1, 0, 0, 16'h00, 1, 16'h22, 1);
        add(0, 1, 0, 1, 16'hA1, 0, 16'h00, 1);   // fill 4 valid words
        add(0, 1, 0, 1, 16'hA2, 0, 16'h00, 2);
        add(0, 1, 0, 1, 16'hA3, 0, 16'h00, 3);
        add(0, 1, 0, 1, 16'hA4, 1, 16'hA1, 4);
        add(0, 1, 1, 1, 16'hEE, 0, 16'hA2, 0);   // flush with en=1, EE discarded
        add(0, 1, 0, 0, 16'h00, 0, 16'hA3, 0);
        add(0, 1, 0, 0, 16'h00, 0, 16'hA4, 0);
        add(0, 1, 0, 0, 16'h00, 0, 16'hEE, 0);
        add(0, 1, 0, 1, 16'hB1, 0, 16'h00, 1);
        add(0, 1, 0, 1, 16'hB2, 0, 16'h00, 2);
        add(0, 1, 0, 1, 16'hB3, 0, 16'h00, 3);
        add(0, 1, 0, 1, 16'hB4, 1, 16'hB1, 4);
        add(0, 0, 1, 1, 16'hFF, 0, 16'hB1, 0);   // flush with en=0: data holds
        add(0, 1, 0, 1, 16'hC1, 0, 16'hB2, 1);
        add(0, 1, 0, 1, 16'hC2, 0, 16'hB3, 2);
        add(1, 1, 1, 1, 16'hD1, 0, 16'h00, 0);   // reset + flush mid-stream
        add(0, 1, 0, 1, 16'hD2, 0, 16'h00, 1);
        add(0, 1, 0, 0, 16'h00, 0, 16'h00, 1);
        add(0, 1, 0, 0, 16'h00, 0, 16'h00, 1);
        add(0, 1, 0, 0, 16'h00, 1, 16'hD2, 1);
        add(0, 1, 0, 0, 16'h00, 0, 16'h00, 0);

        add1(1, 0, 0, 0, 16'h0000, 0, 16'hA5A5, 0);
        add1(0, 1, 0, 1, 16'hBEEF, 1, 16'hBEEF, 1);
        add1(0, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 1);
        add1(0, 1, 0, 0, 16'h1234, 0, 16'h1234, 0);
        add1(0, 1, 1, 1, 16'h5678, 0, 16'h5678, 0);
        add1(0, 1, 0, 1, 16'h9ABC, 1, 16'h9ABC, 1);
        add1(0, 1, 0, 1, 16'hDEF0, 1, 16'hDEF0, 1);
        add1(1, 1, 0, 1, 16'h1111, 0, 16'hA5A5, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; fl = vecs[i].fl;
            iv  = vecs[i].iv;  din = vecs[i].d[7:0];
            @(posedge clk); #1;
            chk($sformatf("d4 row%0d out_valid", i), 32'(dval), 32'(vecs[i].ev));
            chk($sformatf("d4 row%0d output_q", i), 32'(dout), 32'(vecs[i].eq[7:0]));
`ifdef FLOPD_PIPE_OCC_EN
            chk($sformatf("d4 row%0d occupancy", i), 32'(occ), 32'(vecs[i].eo));
`endif
        end

        // Random-enable phase, checked against a scoreboard queue and a valid-bit model.
        // The pipe is empty of valid words after the table.
        pat = 5'b01101;   // in_valid pattern 1,0,1,1,0 read from bit 0 upward
        for (int k = 0; k < 4; k++) mv[k] = 1'b0;
        for (int c = 0; c < 24; c++) begin
            logic       e, v;
            logic [7:0] d;
            e = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            v = (c >= 20) ? 1'b0 : pat[c % 5];
            d = 8'($urandom_range(0, 255));
            rst = 1'b0; fl = 1'b0; en = e; iv = v; din = d;
            if (e && v) sb.push_back(d);
            @(posedge clk); #1;
            if (e) begin
                for (int k = 3; k > 0; k--) mv[k] = mv[k-1];
                mv[0] = v;
            end
            chk($sformatf("rand c%0d out_valid", c), 32'(dval), 32'(mv[3]));
            if (e && dval) begin
                if (sb.size() == 0) begin
                    chk($sformatf("rand c%0d unexpected word", c), 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("rand c%0d output_q", c), 32'(dout), 32'(sb.pop_front()));
                end
            end
`ifdef FLOPD_PIPE_OCC_EN
            chk($sformatf("rand c%0d occupancy", c), 32'(occ), 32'(sb.size()) + 32'(mv[3]));
            chk($sformatf("rand c%0d occ range", c), 32'(occ <= 3'd4), 32'd1);
`endif
        end
        chk("rand words lost", 32'(sb.size()), 32'd0);

        foreach (vecs1[i]) begin
            r2 = vecs1[i].rst; e2 = vecs1[i].en; f2 = vecs1[i].fl;
            v2 = vecs1[i].iv;  d2 = vecs1[i].d;
            @(posedge clk); #1;
            chk($sformatf("d1 row%0d out_valid", i), 32'(qv2), 32'(vecs1[i].ev));
            chk($sformatf("d1 row%0d output_q", i), 32'(q2), 32'(vecs1[i].eq));
`ifdef FLOPD_PIPE_OCC_EN
            chk($sformatf("d1 row%0d occupancy", i), 32'(occ2), 32'(vecs1[i].eo));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
